// File: rtl/ttl_pkg.sv
// Shared types and helpers for the TTL counter models: nibble type, per-cycle
// counter action and the priority resolver that picks it.
package ttl_pkg;

  localparam int TTL_CNT_W = 4;

  typedef logic [TTL_CNT_W-1:0] ttl_nibble_t;

  localparam ttl_nibble_t TTL_CNT_MAX = 4'hF;

  typedef enum logic [1:0] {
    OP_HOLD,
    OP_CLR,
    OP_LOAD,
    OP_INC
  } ttl_cnt_op_t;

  // Clear outranks load, load outranks count. A 74161 (sync_clr=0) clears
  // without waiting for a CP edge.
  function automatic ttl_cnt_op_t ttl_resolve_op(
    input logic tick,
    input logic sync_clr,
    input logic clr_n,
    input logic load_n,
    input logic enp,
    input logic ent
  );
    ttl_cnt_op_t op;
    op = OP_HOLD;
    if (!clr_n && (!sync_clr || tick)) begin
      op = OP_CLR;
    end else if (tick && !load_n) begin
      op = OP_LOAD;
    end else if (tick && enp && ent) begin
      op = OP_INC;
    end
    return op;
  endfunction

  function automatic ttl_nibble_t ttl_next_count(
    input ttl_cnt_op_t op,
    input ttl_nibble_t q,
    input ttl_nibble_t data
  );
    ttl_nibble_t nxt;
    case (op)
      OP_CLR:  nxt = '0;
      OP_LOAD: nxt = data;
      OP_INC:  nxt = q + ttl_nibble_t'(1);
      default: nxt = q;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/ttl_pin_sync.sv
// Two-flop synchroniser for asynchronous board pins: a bank of level inputs
// plus one strobe input whose rising edge is reported as a one-cycle pulse.
module ttl_pin_sync #(
  parameter int           W          = 1,
  parameter logic [W-1:0] RST_VAL    = '0,
  parameter logic         STROBE_RST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         strobe_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o,
  output logic         rise_o
);

  logic [W-1:0] d_s1_q, d_s2_q;
  logic         st_s1_q, st_s2_q, st_prev_q;
  logic         rise_q, rise_d;

  // Resetting the strobe history to STROBE_RST (normally high) stops a pin
  // that is already high at reset release from looking like a fresh edge.
  assign rise_d = st_s2_q & ~st_prev_q;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments let every stage sample the previous
    // stage's old value, which is what makes this a shift chain.
    if (rst) begin
      d_s1_q    <= RST_VAL;
      d_s2_q    <= RST_VAL;
      st_s1_q   <= STROBE_RST;
      st_s2_q   <= STROBE_RST;
      st_prev_q <= STROBE_RST;
      rise_q    <= 1'b0;
    end else begin
      d_s1_q    <= d_i;
      d_s2_q    <= d_s1_q;
      st_s1_q   <= strobe_i;
      st_s2_q   <= st_s1_q;
      st_prev_q <= st_s2_q;
      rise_q    <= rise_d;
    end
  end

  assign q_o    = d_s2_q;
  assign rise_o = rise_q;

endmodule

// File: rtl/ttl_74161_163.sv
// 74161/74163 presettable 4-bit binary counter on the system clock; CP is an
// enable. Macro TTL_CP_EDGE_DETECT_EN adds pin synchronisers and CP edge detect.
module ttl_74161_163
  import ttl_pkg::*;
#(
  parameter bit SYNC_CLR = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic CP,
  input  logic CLR_n,
  input  logic LOAD_n,
  input  logic ENP,
  input  logic ENT,
  input  logic A,
  input  logic B,
  input  logic C,
  input  logic D,
  output logic QA,
  output logic QB,
  output logic QC,
  output logic QD,
  output logic RCO
);

  logic        tick;
  logic        clr_n_s, load_n_s, enp_s, ent_s;
  ttl_nibble_t data_s;

`ifdef TTL_CP_EDGE_DETECT_EN
  localparam int             LVL_W   = 8;
  // Level pins in order {CLR_n, LOAD_n, ENP, ENT, D, C, B, A}.
  localparam logic [LVL_W-1:0] LVL_RST = 8'b1100_0000;

  logic [LVL_W-1:0] lvl_s;

  ttl_pin_sync #(
    .W         (LVL_W),
    .RST_VAL   (LVL_RST),
    .STROBE_RST(1'b1)
  ) u_pin_sync (
    .clk     (clk),
    .rst     (rst),
    .strobe_i(CP),
    .d_i     ({CLR_n, LOAD_n, ENP, ENT, D, C, B, A}),
    .q_o     (lvl_s),
    .rise_o  (tick)
  );

  assign {clr_n_s, load_n_s, enp_s, ent_s, data_s} = lvl_s;
`else
  assign tick = CP;
  assign {clr_n_s, load_n_s, enp_s, ent_s, data_s} =
    {CLR_n, LOAD_n, ENP, ENT, D, C, B, A};
`endif

  ttl_cnt_op_t op;
  ttl_nibble_t q_d, q_q;

  always_comb begin
    // NOTE: both outputs are assigned unconditionally so no latch can form.
    op  = ttl_resolve_op(tick, SYNC_CLR, clr_n_s, load_n_s, enp_s, ent_s);
    q_d = ttl_next_count(op, q_q, data_s);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign {QD, QC, QB, QA} = q_q;
  assign RCO              = ent_s & (q_q == TTL_CNT_MAX);

endmodule

// File: tb/tb_ttl_74161_163.sv
// Directed bench for ttl_74161_163: a 74163 and a 74161 instance share stimulus;
// a vector table covers load/count/enable/clear, hand sequences cover timing.
module tb_ttl_74161_163;

  logic clk = 1'b0;
  logic rst, cp, clr_n, load_n, enp, ent;
  logic [3:0] data;
  wire  [3:0] q163, q161;
  wire        rco163, rco161;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ttl_74161_163 #(.SYNC_CLR(1'b1)) dut163 (
    .clk(clk), .rst(rst), .CP(cp), .CLR_n(clr_n), .LOAD_n(load_n),
    .ENP(enp), .ENT(ent), .A(data[0]), .B(data[1]), .C(data[2]), .D(data[3]),
    .QA(q163[0]), .QB(q163[1]), .QC(q163[2]), .QD(q163[3]), .RCO(rco163)
  );

  ttl_74161_163 #(.SYNC_CLR(1'b0)) dut161 (
    .clk(clk), .rst(rst), .CP(cp), .CLR_n(clr_n), .LOAD_n(load_n),
    .ENP(enp), .ENT(ent), .A(data[0]), .B(data[1]), .C(data[2]), .D(data[3]),
    .QA(q161[0]), .QB(q161[1]), .QC(q161[2]), .QD(q161[3]), .RCO(rco161)
  );

  typedef struct {
    string      name;
    logic       clr_n;
    logic       load_n;
    logic       enp;
    logic       ent;
    logic [3:0] data;
    logic [3:0] exp_q;
    logic       exp_rco;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_pins(input logic c, input logic l, input logic p,
                          input logic t, input logic [3:0] d);
    clr_n  = c;
    load_n = l;
    enp    = p;
    ent    = t;
    data   = d;
  endtask

  // One CP rising edge; returns once the resulting Q update has happened.
  task automatic cp_pulse();
`ifdef TTL_CP_EDGE_DETECT_EN
    cp = 1'b1;
    step(2);
    cp = 1'b0;
    step(2);
`else
    cp = 1'b1;
    step(1);
    cp = 1'b0;
`endif
  endtask

  task automatic check_both(input string name, input logic [3:0] q, input logic r);
    check({name, "_q163"}, {4'h0, q163}, {4'h0, q});
    check({name, "_rco163"}, {7'h0, rco163}, {7'h0, r});
    check({name, "_q161"}, {4'h0, q161}, {4'h0, q});
    check({name, "_rco161"}, {7'h0, rco161}, {7'h0, r});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] exp_q;

    vecs[0]  = '{"load_a",      1'b1, 1'b0, 1'b1, 1'b1, 4'hA, 4'hA, 1'b0};
    vecs[1]  = '{"inc_b",       1'b1, 1'b1, 1'b1, 1'b1, 4'h0, 4'hB, 1'b0};
    vecs[2]  = '{"inc_c",       1'b1, 1'b1, 1'b1, 1'b1, 4'h0, 4'hC, 1'b0};
    vecs[3]  = '{"enp0_hold",   1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 4'hC, 1'b0};
    vecs[4]  = '{"ent0_hold",   1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 4'hC, 1'b0};
    vecs[5]  = '{"load_f",      1'b1, 1'b0, 1'b0, 1'b1, 4'hF, 4'hF, 1'b1};
    vecs[6]  = '{"f_enp0_hold", 1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 4'hF, 1'b1};
    vecs[7]  = '{"f_ent0_rco0", 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'hF, 1'b0};
    vecs[8]  = '{"wrap_0",      1'b1, 1'b1, 1'b1, 1'b1, 4'h0, 4'h0, 1'b0};
    vecs[9]  = '{"clr_vs_load", 1'b0, 1'b0, 1'b1, 1'b1, 4'h5, 4'h0, 1'b0};
    vecs[10] = '{"load_7",      1'b1, 1'b0, 1'b1, 1'b1, 4'h7, 4'h7, 1'b0};
    vecs[11] = '{"clr_vs_inc",  1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 4'h0, 1'b0};
    vecs[12] = '{"load_vs_inc", 1'b1, 1'b0, 1'b1, 1'b1, 4'hE, 4'hE, 1'b0};
    vecs[13] = '{"inc_f",       1'b1, 1'b1, 1'b1, 1'b1, 4'h0, 4'hF, 1'b1};
    vecs[14] = '{"inc_wrap",    1'b1, 1'b1, 1'b1, 1'b1, 4'h0, 4'h0, 1'b0};

    // Reset state.
    rst = 1'b1;
    cp  = 1'b0;
    set_pins(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
    step(2);
    check_both("reset", 4'h0, 1'b0);
    rst = 1'b0;

    // Count 17 CP edges from zero.
    set_pins(1'b1, 1'b1, 1'b1, 1'b1, 4'h0);
    step(3);
    check_both("pre_count", 4'h0, 1'b0);
    for (int i = 1; i <= 17; i++) begin
      cp_pulse();
      exp_q = 4'(i % 16);
      check_both("count", exp_q, exp_q == 4'hF);
    end

    // Table: load/count priority, enables, RCO gating, clear priority.
    for (int i = 0; i < 15; i++) begin
      set_pins(vecs[i].clr_n, vecs[i].load_n, vecs[i].enp, vecs[i].ent, vecs[i].data);
      cp_pulse();
      check_both(vecs[i].name, vecs[i].exp_q, vecs[i].exp_rco);
    end

    // Clear with no CP edge: 74161 clears, 74163 waits for CP.
    set_pins(1'b1, 1'b0, 1'b0, 1'b0, 4'h7);
    cp_pulse();
    check_both("pre_clr", 4'h7, 1'b0);
    set_pins(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
`ifdef TTL_CP_EDGE_DETECT_EN
    step(3);
`else
    step(1);
`endif
    check("clr161_async", {4'h0, q161}, 8'h00);
    check("clr163_waits", {4'h0, q163}, 8'h07);
    step(4);
    check("clr163_still", {4'h0, q163}, 8'h07);
    cp_pulse();
    check("clr163_on_cp", {4'h0, q163}, 8'h00);
    set_pins(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
    step(3);

    // Reset in the middle of counting, with no count afterwards until CP
    // goes through a full low->high.
    set_pins(1'b1, 1'b0, 1'b0, 1'b0, 4'h5);
    cp_pulse();
    check_both("pre_rst", 4'h5, 1'b0);
    set_pins(1'b1, 1'b1, 1'b1, 1'b1, 4'h0);
    step(3);
`ifdef TTL_CP_EDGE_DETECT_EN
    cp = 1'b1;
    step(1);
    rst = 1'b1;
    step(1);
    check_both("rst_mid", 4'h0, 1'b0);
    rst = 1'b0;
    step(5);
    check_both("rst_cp_high", 4'h0, 1'b0);
    cp = 1'b0;
    step(2);
`else
    rst = 1'b1;
    step(1);
    check_both("rst_mid", 4'h0, 1'b0);
    rst = 1'b0;
    step(3);
    check_both("rst_no_cp", 4'h0, 1'b0);
`endif
    cp_pulse();
    check_both("post_rst_inc", 4'h1, 1'b0);

    // CP-to-Q latency.
    step(2);
    cp = 1'b1;
`ifdef TTL_CP_EDGE_DETECT_EN
    for (int k = 0; k < 3; k++) begin
      step(1);
      check("lat_wait", {4'h0, q163}, 8'h01);
    end
    step(1);
    check("lat_n3", {4'h0, q163}, 8'h02);
    step(1);
    cp = 1'b0;
    step(4);
    check("lat_single", {4'h0, q163}, 8'h02);
`else
    step(1);
    check("lat_1", {4'h0, q163}, 8'h02);
    cp = 1'b0;
    step(2);
    check("lat_single", {4'h0, q163}, 8'h02);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ttl_74161_163.md
Name: ttl_74161_163

Overview:
- Clock-domain-accurate model of the 74161/74163 synchronous presettable 4-bit binary counter for board recreations built from the TTL gate library.
- Sits upstream of the NAND gate models: its QA..QD/RCO outputs feed 7400/7401 decode logic.
- The chip's CP pin is not used as an FPGA clock. All state runs on the single system clock, and CP edges are detected as enables.

Parameters:
- SYNC_CLR, 1: 1 = 74163 (clear acts only on a CP edge); 0 = 74161 (clear acts immediately, independent of CP).

Ports:
- clk  in  1  system clock; all flops on rising edge.
- rst  in  1  synchronous, active-high reset.
- CP  in  1  chip clock pin.
- CLR_n  in  1  clear, active low.
- LOAD_n  in  1  parallel load, active low.
- ENP  in  1  count enable P.
- ENT  in  1  count enable T; also gates RCO.
- A, B, C, D  in  1 each  parallel data; A = LSB.
- QA, QB, QC, QD  out  1 each  counter state; QA = LSB.
- RCO  out  1  ripple carry out.

Behaviour:
- Reset: when rst=1 at a clk edge, Q=0000 and RCO=0. Synchroniser/edge flops load CP=1, CLR_n=1, LOAD_n=1, ENP=0, ENT=0, data=0, cp_prev=1. This prevents a spurious edge when CP is already high after reset. rst overrides every other input, including mid-count.
- Input conditioning (macro on):
  - Every pin input passes through a 2-flop synchroniser; all decisions use synchronised values, so data stays aligned with CP.
  - tick = cp_s2 & ~cp_prev.
  - Latency: CP sampled high at edge n gives tick=1 during cycle n+2 and Q update at edge n+3.
- Action on a clk edge with tick=1, priority high to low:
  - CLR_n=0 and SYNC_CLR=1: Q=0.
  - LOAD_n=0: Q={D,C,B,A}.
  - ENP=1 and ENT=1: Q=Q+1, mod 16 (15 wraps to 0).
  - Otherwise: hold.
- SYNC_CLR=0: synchronised CLR_n=0 forces Q=0 on every clk edge regardless of tick, and outranks load/count.
- Without tick (and without a 74161 clear): Q holds.
- RCO is combinational: RCO = ENT & (Q==4'hF), using synchronised ENT and registered Q. It has no tick dependency.
- Simultaneous events:
  - LOAD_n=0 with ENP=ENT=1: load wins.
  - CLR_n=0 with LOAD_n=0: clear wins.
  - CP rising at or after rst deassertion: no tick unless CP is seen low for at least one synchronised cycle first.
- A CP pulse shorter than one clk period may be missed. CP must hold each level at least 2 clk periods.

Optional Feature:
- Macro TTL_CP_EDGE_DETECT_EN.
- Defined: synchronisers and edge detection as above (asynchronous board signals).
- Undefined:
  - No synchronisers.
  - CP is a fabric clock-enable strobe: tick = CP, sampled directly.
  - All inputs are used unsynchronised.
  - Q updates at the same clk edge where CP=1, with latency 1.
  - The SYNC_CLR=0 clear also takes effect at the next clk edge.

Decomposition:
- Package ttl_pkg:
  - constant TTL_CNT_W = 4
  - constant TTL_CNT_MAX = 4'hF
  - typedef ttl_nibble_t (logic [3:0])
  - enum ttl_cnt_op_t {OP_HOLD, OP_CLR, OP_LOAD, OP_INC} for the resolved per-cycle action.
- Sub-module ttl_pin_sync:
  - Parameterised width and reset value.
  - 2-flop synchroniser plus optional rising-edge output.
  - Reused by later sequential TTL models (74164, 74174, 74193).

Test Plan:
- Reset then count: rst 2 clk, then ENP=ENT=1, LOAD_n=CLR_n=1, 17 CP rising edges -> Q 0,1,…,F,0,1. RCO=1 only while Q=F; last Q=1.
- Load priority: DCBA=1010, LOAD_n=0, ENP=ENT=1, one CP edge -> Q=1010. Then LOAD_n=1 and next edge -> Q=1011.
- Clear variants: Q=0111, CLR_n=0, no CP edges.
  - SYNC_CLR=0 -> Q=0000 within 3 clk (macro on) or 1 clk (off).
  - SYNC_CLR=1 -> Q stays 0111 until a CP edge, then 0000.
- Enable/RCO gating: Q=F, ENP=0, ENT=1 -> RCO=1 and CP edges hold Q=F. ENT=0 -> RCO=0 and Q holds.
- Latency (macro on): CP 0->1 sampled at edge n -> Q changes at edge n+3. After rst with CP held high -> no increment.
- Reset mid-operation: rst=1 during counting at Q=0101 -> Q=0000 at the next clk and RCO=0. No increment until the next full CP low->high.
